// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding selects, load-use stall, branch flush, memory-wait freeze with timeout.
// Optional performance counters built only when HAZARD_PERF_EN is defined.
module hazard_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int PERF_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        Rs1E,
  input  logic [4:0]        Rs2E,
  input  logic [4:0]        RdE,
  input  logic [4:0]        RdM,
  input  logic [4:0]        RdW,
  input  logic              ResultSrcEb0,
  input  logic              PCSrcE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              StallW,
  output logic              FlushD,
  output logic              FlushE,
  output logic              MemErr,
  output logic [PERF_W-1:0] StallCount,
  output logic [PERF_W-1:0] FlushCount
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  logic [7:0] waitCnt;
  logic       memWait;
  logic       lwStall;
  logic       freeze;

  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)      ForwardAE = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ForwardAE = 2'b01;

    ForwardBE = 2'b00;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)      ForwardBE = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ForwardBE = 2'b01;
  end

  assign memWait = MemReqM && !MemReadyM;
  assign lwStall = ResultSrcEb0 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
  assign freeze  = memWait || (state == S_ERR);

  // A frozen pipeline holds every stage; branch/load-use inputs stay put and act on release.
  always_comb begin
    if (freeze) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      StallW = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
    end else begin
      StallF = lwStall;
      StallD = lwStall;
      StallE = 1'b0;
      StallM = 1'b0;
      StallW = 1'b0;
      FlushD = PCSrcE;
      FlushE = lwStall || PCSrcE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_RUN;
      waitCnt <= 8'd0;
      MemErr  <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (memWait) begin
            state   <= S_WAIT;
            waitCnt <= waitCnt + 8'd1;
          end else begin
            waitCnt <= 8'd0;
          end
        end
        S_WAIT: begin
          // Ready arriving on the last allowed cycle still wins over the timeout.
          if (!memWait) begin
            state   <= S_RUN;
            waitCnt <= 8'd0;
          end else if (waitCnt == LAST_WAIT) begin
            state   <= S_ERR;
            MemErr  <= 1'b1;
            waitCnt <= waitCnt + 8'd1;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        S_ERR: begin
          MemErr <= 1'b1;
        end
        default: begin
          state   <= S_RUN;
          waitCnt <= 8'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF && !(&StallCount)) StallCount <= StallCount + 1'b1;
      if (FlushE && !(&FlushCount)) FlushCount <= FlushCount + 1'b1;
    end
  end
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized and directed bench for hazard_unit against a behavioural model of the hazard rules.
module tb_hazard_unit;
  localparam int TO = 4;
  localparam int PW = 4;
  localparam int CNT_MAX = (1 << PW) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [4:0] Rs1D = 0, Rs2D = 0, Rs1E = 0, Rs2E = 0, RdE = 0, RdM = 0, RdW = 0;
  logic ResultSrcEb0 = 0, PCSrcE = 0, RegWriteM = 0, RegWriteW = 0, MemReqM = 0, MemReadyM = 0;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MemErr;
  logic [PW-1:0] StallCount, FlushCount;

  int checkCnt = 0;
  int passCnt = 0;

  // Model state: length of the current run of wait cycles, sticky error, event counters.
  int  mRun = 0;
  bit  mErr = 0;
  int  mStall = 0;
  int  mFlush = 0;

  hazard_unit #(.MEM_TIMEOUT(TO), .PERF_W(PW)) dut (
    .clock(clock), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcEb0(ResultSrcEb0), .PCSrcE(PCSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .MemErr(MemErr),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [1:0] fwdSel(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit isWait();
    return MemReqM && !MemReadyM;
  endfunction

  function automatic bit isLoadUse();
    return ResultSrcEb0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
  endfunction

  function automatic bit frozen();
    return isWait() || mErr;
  endfunction

  function automatic logic [4:0] expStalls();
    if (frozen()) return 5'b11111;
    return isLoadUse() ? 5'b11000 : 5'b00000;
  endfunction

  function automatic logic [1:0] expFlushes();
    if (frozen()) return 2'b00;
    return {PCSrcE, isLoadUse() || PCSrcE};
  endfunction

  task automatic checkAll(input string ctx);
    checkVal({ctx, ".fwdA"}, 32'(ForwardAE), 32'(fwdSel(Rs1E)));
    checkVal({ctx, ".fwdB"}, 32'(ForwardBE), 32'(fwdSel(Rs2E)));
    checkVal({ctx, ".stalls"}, 32'({StallF, StallD, StallE, StallM, StallW}), 32'(expStalls()));
    checkVal({ctx, ".flushes"}, 32'({FlushD, FlushE}), 32'(expFlushes()));
    checkVal({ctx, ".memErr"}, 32'(MemErr), 32'(mErr));
`ifdef HAZARD_PERF_EN
    checkVal({ctx, ".stallCnt"}, 32'(StallCount), 32'(mStall));
    checkVal({ctx, ".flushCnt"}, 32'(FlushCount), 32'(mFlush));
`else
    checkVal({ctx, ".stallCnt"}, 32'(StallCount), 32'd0);
    checkVal({ctx, ".flushCnt"}, 32'(FlushCount), 32'd0);
`endif
  endtask

  // Advance the model across one rising edge using the inputs present at that edge.
  task automatic modelEdge();
    logic [4:0] s;
    logic [1:0] f;
    s = expStalls();
    f = expFlushes();
    if (s[4] && mStall < CNT_MAX) mStall++;
    if (f[0] && mFlush < CNT_MAX) mFlush++;
    if (!mErr) begin
      if (isWait()) begin
        mRun++;
        if (mRun == TO) mErr = 1;
      end else begin
        mRun = 0;
      end
    end
  endtask

  task automatic cycle(input string ctx);
    @(negedge clock);
    checkAll(ctx);
    @(posedge clock);
    if (!reset) modelEdge();
    #1;
  endtask

  task automatic clearInputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {ResultSrcEb0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM} = '0;
  endtask

  // Reset is raised between edges so the async clear is observed before any clock.
  task automatic doReset(input string ctx);
    reset = 1'b1;
    mRun = 0; mErr = 0; mStall = 0; mFlush = 0;
    #1;
    checkAll({ctx, ".async"});
    @(negedge clock);
    checkAll(ctx);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1;
    doReset("reset");

    RegWriteM = 1; RdM = 5; Rs1E = 5; RegWriteW = 1; RdW = 5; Rs2E = 5;
    cycle("fwdMW");
    RdM = 0;
    cycle("fwdRdM0");
    RdM = 5; Rs2E = 5;
    cycle("fwdMprio");
    clearInputs();

    ResultSrcEb0 = 1; RdE = 7; Rs2D = 7;
    repeat (3) cycle("loadUse");
    RdE = 0;
    cycle("loadUseRd0");
    clearInputs();

    PCSrcE = 1;
    repeat (2) cycle("branch");
    ResultSrcEb0 = 1; RdE = 3; Rs1D = 3;
    cycle("branchLw");
    clearInputs();

    PCSrcE = 1; MemReqM = 1; MemReadyM = 0;
    repeat (3) cycle("memWait");
    MemReadyM = 1;
    cycle("memRelease");
    MemReqM = 0; PCSrcE = 0;
    cycle("afterRelease");

    doReset("resetTo");
    MemReqM = 1; MemReadyM = 0;
    repeat (3) cycle("boundaryWait");
    MemReadyM = 1;
    cycle("boundaryReady");
    MemReqM = 0;
    cycle("boundaryRun");

    MemReqM = 1; MemReadyM = 0;
    repeat (4) cycle("timeoutWait");
    MemReadyM = 1; PCSrcE = 1; ResultSrcEb0 = 1; RdE = 9; Rs1D = 9;
    repeat (2) cycle("errSticky");
    doReset("resetErr");
    repeat (2) cycle("afterErrReset");
    clearInputs();

    MemReqM = 1; MemReadyM = 0;
    repeat (2) cycle("midWait");
    doReset("resetMidWait");
    clearInputs();

    ResultSrcEb0 = 1; RdE = 4; Rs1D = 4;
    repeat (20) cycle("saturate");
    clearInputs();
    cycle("saturated");

    for (int i = 0; i < 2000; i++) begin
      if (i % 150 == 149) doReset("randReset");
      Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
      Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
      RdE  = 5'($urandom_range(0, 7)); RdM  = 5'($urandom_range(0, 7));
      RdW  = 5'($urandom_range(0, 7));
      ResultSrcEb0 = 1'($urandom_range(0, 1));
      PCSrcE = ($urandom_range(0, 3) == 0);
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      MemReqM = 1'($urandom_range(0, 1));
      MemReadyM = ($urandom_range(0, 2) != 0);
      cycle("random");
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
